// File: rtl/maze_map_store.sv
// Writable maze map store: loads a map (row words plus start/end points) from a
// byte-wide ROM, then serves registered cell queries and run-time door writes.
module maze_map_store #(
    parameter int COLS = 8,
    parameter int ROWS = 8,
    parameter int RW   = 3,
    parameter int CW   = 3,
    parameter int MSW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_req,
    input  logic [MSW-1:0]       map_sel,
    output logic                 busy,
    output logic                 load_done,
    output logic                 map_valid,
    output logic                 rom_en,
    output logic [MSW+RW:0]      rom_addr,
    input  logic [COLS-1:0]      rom_data,
    input  logic                 q_valid,
    input  logic [RW-1:0]        q_row,
    input  logic [CW-1:0]        q_col,
    output logic                 q_ack,
    output logic                 q_open,
    output logic                 q_start,
    output logic                 q_end,
    input  logic                 w_en,
    input  logic [RW-1:0]        w_row,
    input  logic [CW-1:0]        w_col,
    input  logic                 w_open,
    output logic [RW-1:0]        start_row,
    output logic [CW-1:0]        start_col,
    output logic [RW-1:0]        end_row,
    output logic [CW-1:0]        end_col
);

    localparam int IW  = RW + 1;
    localparam int CWX = CW + 1;
    localparam logic [RW:0] ROWS_I   = IW'(ROWS);
    localparam logic [RW:0] LAST_IDX = IW'(ROWS + 1);
    localparam logic [CW:0] COLS_I   = CWX'(COLS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state;
    logic [MSW-1:0]     sel;
    logic               cap_v;
    logic [RW:0]        cap_idx;
    // Ascending packed range so that the word MSB lands on column 0.
    logic [0:COLS-1]    rows [2**RW];

    logic q_in;
    logic w_in;

    always_comb begin
        q_in = ({1'b0, q_row} < ROWS_I) && ({1'b0, q_col} < COLS_I);
        w_in = ({1'b0, w_row} < ROWS_I) && ({1'b0, w_col} < COLS_I);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            map_valid <= 1'b0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            cap_v     <= 1'b0;
            cap_idx   <= '0;
            rows      <= '{default: '0};
            start_row <= '0;
            start_col <= '0;
            end_row   <= '0;
            end_col   <= '0;
            q_ack     <= 1'b0;
            q_open    <= 1'b0;
            q_start   <= 1'b0;
            q_end     <= 1'b0;
        end else begin
            load_done <= 1'b0;
            // Word issued at edge k is on rom_data after k+1 and captured at k+2.
            cap_v   <= rom_en;
            cap_idx <= rom_addr[RW:0];

            case (state)
                IDLE: begin
                    if (load_req) begin
                        sel       <= map_sel;
                        rom_addr  <= {map_sel, IW'(0)};
                        rom_en    <= 1'b1;
                        busy      <= 1'b1;
                        map_valid <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rom_addr[RW:0] == LAST_IDX) begin
                        rom_en <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        rom_addr <= {sel, rom_addr[RW:0] + IW'(1)};
                    end
                end
                DRAIN: begin
                    busy      <= 1'b0;
                    load_done <= 1'b1;
                    map_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (cap_v) begin
                if (cap_idx < ROWS_I) begin
                    rows[cap_idx[RW-1:0]] <= rom_data;
                end else if (cap_idx == ROWS_I) begin
                    start_row <= rom_data[RW+CW-1:CW];
                    start_col <= rom_data[CW-1:0];
                end else begin
                    end_row <= rom_data[RW+CW-1:CW];
                    end_col <= rom_data[CW-1:0];
                end
            end

            if (w_en && map_valid && !busy && w_in) begin
                rows[w_row][w_col] <= w_open;
            end

            q_ack   <= q_valid;
            q_open  <= q_valid && map_valid && q_in && rows[q_row][q_col];
            q_start <= q_valid && map_valid && q_in && (q_row == start_row) && (q_col == start_col);
            q_end   <= q_valid && map_valid && q_in && (q_row == end_row) && (q_col == end_col);
        end
    end

endmodule
